// File: rtl/hci_core_r_id_fifo_pkg.sv
// Shared constants and HCI size descriptor used by the r_id FIFO slice.
// No ports; imported by the interface users and the r_id FIFO modules.
package hci_core_r_id_fifo_pkg;

  localparam int unsigned HCI_R_ID_FIFO_DEPTH_DEFAULT = 4;

  // Width descriptor of one HCI port; IW and EHW are taken from it.
  typedef struct packed {
    int unsigned DW;
    int unsigned AW;
    int unsigned BW;
    int unsigned UW;
    int unsigned IW;
    int unsigned EW;
    int unsigned EHW;
  } hci_size_parameter_t;

  localparam hci_size_parameter_t HCI_SIZE_DEFAULT = '{
    DW: 32, AW: 32, BW: 8, UW: 1, IW: 8, EW: 1, EHW: 0
  };

endpackage

// File: rtl/hci_core_intf.sv
// Minimal HCI core interface: request channel, response channel, and the
// ECC handshake replicas (kept 1 bit wide when EHW is 0).
// Modports: initiator (drives requests) and target (drives responses).
interface hci_core_intf #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned BW  = 8,
  parameter int unsigned UW  = 1,
  parameter int unsigned IW  = 8,
  parameter int unsigned EW  = 1,
  parameter int unsigned EHW = 0
) ();

  localparam int unsigned EHW_W = (EHW > 0) ? EHW : 1;

  logic             req;
  logic             gnt;
  logic [AW-1:0]    add;
  logic             wen;
  logic [DW-1:0]    data;
  logic [DW/BW-1:0] be;
  logic [UW-1:0]    user;
  logic [IW-1:0]    id;
  logic [EW-1:0]    ecc;
  logic [EHW_W-1:0] ereq;
  logic [EHW_W-1:0] egnt;

  logic [DW-1:0]    r_data;
  logic             r_valid;
  logic             r_ready;
  logic [UW-1:0]    r_user;
  logic [IW-1:0]    r_id;
  logic             r_opc;
  logic [EW-1:0]    r_ecc;
  logic [EHW_W-1:0] r_evalid;
  logic [EHW_W-1:0] r_eready;

  modport initiator (
    output req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready,
    input  gnt, egnt, r_data, r_valid, r_user, r_id, r_opc, r_ecc, r_evalid
  );

  modport target (
    input  req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready,
    output gnt, egnt, r_data, r_valid, r_user, r_id, r_opc, r_ecc, r_evalid
  );

endinterface

// File: rtl/hci_core_r_id_fifo_buf.sv
// Circular id storage with push/pop, synchronous flush and occupancy flags.
// Ports: clk_i, rst_ni, clear_i, push_i/data_i (write at tail),
//        pop_i/data_o (head, combinational from storage),
//        full_o, empty_o, count_o (registered).
module hci_core_r_id_fifo_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [ID_W-1:0]            data_i,
  input  logic                       pop_i,
  output logic [ID_W-1:0]            data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] used_d;
  logic [CNT_W-1:0] count_q;
  logic             full_q;
  logic             empty_q;
  logic [ID_W-1:0]  mem_q [DEPTH];

  // Next pointers; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Wrap bit makes the pointer difference the exact occupancy 0..DEPTH.
  assign used_d = wr_ptr_d - rd_ptr_d;

  // Pointers and flags, all derived from the next pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= CNT_W'(used_d);
      full_q   <= (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]) &&
                  (wr_ptr_d[IDX_W] != rd_ptr_d[IDX_W]);
      empty_q  <= (wr_ptr_d == rd_ptr_d);
    end
  end

  // Storage; flush only rewinds pointers, contents are kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !clear_i) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/hci_core_r_id_fifo.sv
// Tracks ids of granted HCI transactions in order and returns them on r_id
// alongside r_valid, for memory sides with variable read latency.
// Ports: clk_i, rst_ni, clear_i (flush), enable_i (0 = transparent),
//        tcdm_target (upstream, carries id), tcdm_initiator (downstream,
//        id driven '0), outstanding_o, full_o, err_o (sticky empty response).
module hci_core_r_id_fifo
  import hci_core_r_id_fifo_pkg::*;
#(
  parameter int unsigned         DEPTH                = HCI_R_ID_FIFO_DEPTH_DEFAULT,
  parameter bit                  WRITE_RESP           = 1'b0,
  parameter bit                  CHECK_RVALID_EMPTY   = 1'b1,
  parameter hci_size_parameter_t HCI_SIZE_tcdm_target = HCI_SIZE_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       enable_i,
  hci_core_intf.target               tcdm_target,
  hci_core_intf.initiator            tcdm_initiator,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       full_o,
  output logic                       err_o
);

  localparam int unsigned IW  = HCI_SIZE_tcdm_target.IW;
  localparam int unsigned EHW = HCI_SIZE_tcdm_target.EHW;

  logic          gate_full;
  logic          req_c;
  logic          gnt_c;
  logic          track;
  logic          push;
  logic          pop;
  logic          empty;
  logic          spurious;
  logic [IW-1:0] head_id;
  logic          err_q;
  logic          unused_ecc;

  // Back-pressure only while tracking; a same-cycle pop does not bypass full.
  assign gate_full = enable_i & full_o;
  assign req_c     = tcdm_target.req & ~gate_full;
  assign gnt_c     = tcdm_initiator.gnt & ~gate_full;

  assign track    = enable_i & (tcdm_target.wen | WRITE_RESP);
  assign push     = tcdm_target.req & gnt_c & track;
  assign pop      = tcdm_initiator.r_valid & tcdm_target.r_ready & enable_i & ~empty;
  assign spurious = tcdm_initiator.r_valid & enable_i & empty;

  hci_core_r_id_fifo_buf #(
    .DEPTH (DEPTH),
    .ID_W  (IW)
  ) i_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (tcdm_target.id),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (full_o),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  // Sticky error: a response arrived with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       err_q <= 1'b0;
    else if (clear_i)  err_q <= 1'b0;
    else if (spurious) err_q <= 1'b1;
  end
  assign err_o = err_q;

  // Request channel pass-through.
  assign tcdm_initiator.req  = req_c;
  assign tcdm_initiator.add  = tcdm_target.add;
  assign tcdm_initiator.wen  = tcdm_target.wen;
  assign tcdm_initiator.data = tcdm_target.data;
  assign tcdm_initiator.be   = tcdm_target.be;
  assign tcdm_initiator.user = tcdm_target.user;
  assign tcdm_initiator.ecc  = tcdm_target.ecc;
  assign tcdm_initiator.id   = '0;
  assign tcdm_target.gnt     = gnt_c;

  // Response channel pass-through; r_id comes from the head of the FIFO.
  assign tcdm_initiator.r_ready = tcdm_target.r_ready;
  assign tcdm_target.r_data     = tcdm_initiator.r_data;
  assign tcdm_target.r_valid    = tcdm_initiator.r_valid;
  assign tcdm_target.r_user     = tcdm_initiator.r_user;
  assign tcdm_target.r_opc      = tcdm_initiator.r_opc;
  assign tcdm_target.r_ecc      = tcdm_initiator.r_ecc;
  assign tcdm_target.r_id       = (enable_i && !empty) ? head_id : '0;

  // ECC handshake replicas.
  if (EHW > 0) begin : gen_ecc_hs
    assign tcdm_initiator.ereq     = {EHW{req_c}};
    assign tcdm_target.egnt        = {EHW{gnt_c}};
    assign tcdm_target.r_evalid    = {EHW{tcdm_initiator.r_valid}};
    assign tcdm_initiator.r_eready = {EHW{tcdm_target.r_ready}};
  end else begin : gen_no_ecc_hs
    assign tcdm_initiator.ereq     = '0;
    assign tcdm_target.egnt        = '1;
    assign tcdm_target.r_evalid    = '0;
    assign tcdm_initiator.r_eready = '1;
  end

  // Inputs that this stage does not consume.
  assign unused_ecc = ^{tcdm_target.ereq, tcdm_target.r_eready, tcdm_initiator.egnt,
                        tcdm_initiator.r_evalid, tcdm_initiator.r_id};

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full_o));

  if (CHECK_RVALID_EMPTY) begin : gen_chk_rvalid
    a_rvalid_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !(tcdm_initiator.r_valid && enable_i && empty));
  end

  a_depth_pow2: assert property (@(posedge clk_i)
                                 (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
  a_size_data:  assert property (@(posedge clk_i)
                                 $bits(tcdm_target.data) == $bits(tcdm_initiator.data));
  a_size_add:   assert property (@(posedge clk_i)
                                 $bits(tcdm_target.add) == $bits(tcdm_initiator.add));
  a_size_user:  assert property (@(posedge clk_i)
                                 $bits(tcdm_target.user) == $bits(tcdm_initiator.user));
  a_size_id:    assert property (@(posedge clk_i) $bits(tcdm_target.id) == IW);

endmodule

// File: tb/tb_hci_core_r_id_fifo.sv
// Bench for hci_core_r_id_fifo: two instances (WRITE_RESP 0 with EHW 0, and
// WRITE_RESP 1 with EHW 1) share request stimulus; each has its own r_valid
// and its own scoreboard queue of expected ids.
`timescale 1ns/1ps
module tb_hci_core_r_id_fifo;
  import hci_core_r_id_fifo_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam hci_size_parameter_t SZ0 = '{DW: 32, AW: 32, BW: 8, UW: 2, IW: 8, EW: 4, EHW: 0};
  localparam hci_size_parameter_t SZ1 = '{DW: 32, AW: 32, BW: 8, UW: 2, IW: 8, EW: 4, EHW: 1};
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        t_req, t_wen, t_rready, m_gnt, m_rv0, m_rv1, m_ropc, en, clr;
  logic [7:0]  t_id;
  logic [31:0] t_add, t_data, m_rdata;
  logic [3:0]  t_be, t_ecc, m_recc;
  logic [1:0]  t_user, m_ruser;

  logic [CNT_W-1:0] out0, out1;
  logic             full0, full1, err0, err1;

  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(2), .IW(8), .EW(4), .EHW(0)) tgt0 ();
  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(2), .IW(8), .EW(4), .EHW(0)) ini0 ();
  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(2), .IW(8), .EW(4), .EHW(1)) tgt1 ();
  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(2), .IW(8), .EW(4), .EHW(1)) ini1 ();

  assign tgt0.req = t_req;   assign tgt1.req = t_req;
  assign tgt0.add = t_add;   assign tgt1.add = t_add;
  assign tgt0.wen = t_wen;   assign tgt1.wen = t_wen;
  assign tgt0.data = t_data; assign tgt1.data = t_data;
  assign tgt0.be = t_be;     assign tgt1.be = t_be;
  assign tgt0.user = t_user; assign tgt1.user = t_user;
  assign tgt0.id = t_id;     assign tgt1.id = t_id;
  assign tgt0.ecc = t_ecc;   assign tgt1.ecc = t_ecc;
  assign tgt0.ereq = 1'b0;   assign tgt1.ereq = 1'b0;
  assign tgt0.r_ready = t_rready;  assign tgt1.r_ready = t_rready;
  assign tgt0.r_eready = 1'b1;     assign tgt1.r_eready = 1'b1;

  assign ini0.gnt = m_gnt;      assign ini1.gnt = m_gnt;
  assign ini0.egnt = 1'b1;      assign ini1.egnt = 1'b1;
  assign ini0.r_data = m_rdata; assign ini1.r_data = m_rdata;
  assign ini0.r_valid = m_rv0;  assign ini1.r_valid = m_rv1;
  assign ini0.r_user = m_ruser; assign ini1.r_user = m_ruser;
  assign ini0.r_id = 8'hEE;     assign ini1.r_id = 8'hEE;
  assign ini0.r_opc = m_ropc;   assign ini1.r_opc = m_ropc;
  assign ini0.r_ecc = m_recc;   assign ini1.r_ecc = m_recc;
  assign ini0.r_evalid = 1'b0;  assign ini1.r_evalid = 1'b0;

  hci_core_r_id_fifo #(
    .DEPTH(DEPTH), .WRITE_RESP(1'b0), .CHECK_RVALID_EMPTY(1'b0), .HCI_SIZE_tcdm_target(SZ0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .enable_i(en),
    .tcdm_target(tgt0), .tcdm_initiator(ini0),
    .outstanding_o(out0), .full_o(full0), .err_o(err0)
  );

  hci_core_r_id_fifo #(
    .DEPTH(DEPTH), .WRITE_RESP(1'b1), .CHECK_RVALID_EMPTY(1'b0), .HCI_SIZE_tcdm_target(SZ1)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .enable_i(en),
    .tcdm_target(tgt1), .tcdm_initiator(ini1),
    .outstanding_o(out1), .full_o(full1), .err_o(err1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state per instance.
  int         cnt0, cnt1;
  bit         err_m0, err_m1;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cnt0 = 0; cnt1 = 0; err_m0 = 1'b0; err_m1 = 1'b0;
    sb0.delete(); sb1.delete();
  endtask

  // One cycle: drive at negedge, check just after, update model at posedge.
  task automatic step(input bit req, input bit wen, input logic [7:0] id,
                      input bit gnt, input bit rv0, input bit rv1);
    bit g0, g1, rq0, rq1, p0, p1, q0, q1;
    t_req = req; t_wen = wen; t_id = id;
    t_add = {22'h0, id, 2'b00}; t_data = {id, ~id, id, 8'h3C};
    t_be = id[3:0]; t_user = id[1:0]; t_ecc = id[7:4];
    m_gnt = gnt; m_rv0 = rv0; m_rv1 = rv1;
    m_rdata = {id, id, 16'hA5A5}; m_ruser = ~id[1:0]; m_ropc = id[0]; m_recc = ~id[3:0];
    #1;
    rq0 = req && !(en && cnt0 == DEPTH);
    rq1 = req && !(en && cnt1 == DEPTH);
    g0  = gnt && !(en && cnt0 == DEPTH);
    g1  = gnt && !(en && cnt1 == DEPTH);

    check("d0_gnt",   64'(tgt0.gnt), 64'(g0));
    check("d0_req",   64'(ini0.req), 64'(rq0));
    check("d0_r_id",  64'(tgt0.r_id), 64'((en && cnt0 > 0) ? sb0[0] : 8'h00));
    check("d0_outst", 64'(out0), 64'(cnt0));
    check("d0_full",  64'(full0), 64'(cnt0 == DEPTH));
    check("d0_err",   64'(err0), 64'(err_m0));
    check("d1_gnt",   64'(tgt1.gnt), 64'(g1));
    check("d1_req",   64'(ini1.req), 64'(rq1));
    check("d1_r_id",  64'(tgt1.r_id), 64'((en && cnt1 > 0) ? sb1[0] : 8'h00));
    check("d1_outst", 64'(out1), 64'(cnt1));
    check("d1_full",  64'(full1), 64'(cnt1 == DEPTH));
    check("d1_err",   64'(err1), 64'(err_m1));

    check("d0_req_fwd", 64'({ini0.add, ini0.data}), 64'({t_add, t_data}));
    check("d0_req_misc", 64'({ini0.wen, ini0.be, ini0.user, ini0.ecc, ini0.id}),
          64'({t_wen, t_be, t_user, t_ecc, 8'h00}));
    check("d0_rsp_fwd", 64'({tgt0.r_data, tgt0.r_valid, tgt0.r_user, tgt0.r_opc, tgt0.r_ecc, ini0.r_ready}),
          64'({m_rdata, m_rv0, m_ruser, m_ropc, m_recc, t_rready}));
    check("d0_ecc_hs", 64'({ini0.ereq, tgt0.egnt, tgt0.r_evalid, ini0.r_eready}), 64'(4'b0101));
    check("d1_req_fwd", 64'({ini1.add, ini1.data}), 64'({t_add, t_data}));
    check("d1_req_misc", 64'({ini1.wen, ini1.be, ini1.user, ini1.ecc, ini1.id}),
          64'({t_wen, t_be, t_user, t_ecc, 8'h00}));
    check("d1_rsp_fwd", 64'({tgt1.r_data, tgt1.r_valid, tgt1.r_user, tgt1.r_opc, tgt1.r_ecc, ini1.r_ready}),
          64'({m_rdata, m_rv1, m_ruser, m_ropc, m_recc, t_rready}));
    check("d1_ecc_hs", 64'({ini1.ereq, tgt1.egnt, tgt1.r_evalid, ini1.r_eready}),
          64'({rq1, g1, rv1, t_rready}));

    @(posedge clk);
    if (clr) begin
      model_reset();
    end else if (en) begin
      p0 = req && g0 && wen;
      p1 = req && g1;
      q0 = rv0 && t_rready && cnt0 > 0;
      q1 = rv1 && t_rready && cnt1 > 0;
      if (rv0 && cnt0 == 0) err_m0 = 1'b1;
      if (rv1 && cnt1 == 0) err_m1 = 1'b1;
      if (q0) begin void'(sb0.pop_front()); cnt0--; end
      if (q1) begin void'(sb1.pop_front()); cnt1--; end
      if (p0) begin sb0.push_back(id); cnt0++; end
      if (p1) begin sb1.push_back(id); cnt1++; end
    end
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] id);
    step(1'b1, 1'b1, id, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rsp(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; t_rready = 1'b1;
    t_req = 1'b0; t_wen = 1'b1; t_id = '0; t_add = '0; t_data = '0;
    t_be = '0; t_user = '0; t_ecc = '0;
    m_gnt = 1'b1; m_rv0 = 1'b0; m_rv1 = 1'b0; m_rdata = '0;
    m_ruser = '0; m_ropc = 1'b0; m_recc = '0;
    model_reset();

    // Reset state: empty, no error, gnt passes through.
    repeat (3) @(negedge clk);
    check("rst_outst", 64'({out0, out1}), 64'(0));
    check("rst_flags", 64'({full0, full1, err0, err1}), 64'(0));
    check("rst_r_id", 64'({tgt0.r_id, tgt1.r_id}), 64'(0));
    check("rst_gnt", 64'({tgt0.gnt, tgt1.gnt}), 64'(2'b11));
    rst_n = 1'b1;
    @(negedge clk);

    // Single read, response three cycles after grant.
    rd(8'h05);
    idle(2);
    rsp(1);
    idle(1);

    // Fill to DEPTH, stall the 5th request, then drain in order.
    rd(8'h01); rd(8'h02); rd(8'h03); rd(8'h04);
    rd(8'h05); rd(8'h05);
    step(1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1);
    rd(8'h05);
    rsp(4);
    idle(1);

    // Push and pop in the same cycle at occupancy 2.
    rd(8'h10); rd(8'h11);
    step(1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'h13, 1'b1, 1'b1, 1'b1);
    rsp(2);
    idle(1);

    // Write between two reads: tracked only when writes produce responses.
    rd(8'h07);
    step(1'b1, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0);
    rd(8'h09);
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(1);

    // Memory withholding gnt: nothing pushed.
    step(1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Spurious response while empty sets a sticky error; clear drops it.
    rsp(1);
    idle(3);
    rd(8'h20); rd(8'h21);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    idle(2);
    rd(8'h22);
    rsp(1);
    idle(1);

    // Transparent mode: no gating, no tracking, r_id forced to 0.
    en = 1'b0;
    step(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
    en = 1'b1;
    idle(1);

    // Reset with three outstanding, then a fresh read.
    rd(8'h31); rd(8'h32); rd(8'h33);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_outst", 64'({out0, out1}), 64'(0));
    check("mid_rst_full", 64'({full0, full1}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    rd(8'h0A);
    idle(1);
    rsp(1);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
